// File: rtl/gs_mem_arbiter_if.sv
// Byte-wide GS memory requester bus: level rd/wr held until ready, dout valid once ready returns.
interface gs_mem_arbiter_if #(
  parameter int AW = 21
);
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic          rd;
  logic          wr;
  logic [7:0]    dout;
  logic          ready;

  modport master (output addr, din, rd, wr, input dout, ready);
  modport slave  (input addr, din, rd, wr, output dout, ready);
endinterface

// File: rtl/gs_mem_arbiter.sv
// Two-port (GS Z80 high priority, HPS loader low priority) arbiter onto the single ddram byte port.
// Optional GSARB_SIZE_MASK_EN: requests beyond the gs_size limit complete locally (reads 8'hFF).
module gs_mem_arbiter #(
  parameter int AW         = 21,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  gs_mem_arbiter_if.slave port_a,
  gs_mem_arbiter_if.slave port_b,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_din,
  output logic            mem_rd,
  output logic            mem_we,
  input  logic [7:0]      mem_dout,
  input  logic            mem_ready,
  input  logic [1:0]      gs_size
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic          a_req_q, b_req_q;
  logic          a_edge, b_edge;
  logic          pend_a, pend_b;
  logic [AW-1:0] a_addr_q, b_addr_q, sel_addr;
  logic [7:0]    a_din_q, b_din_q, sel_din;
  logic          a_we_q, b_we_q, sel_we;
  logic          grant_b, starved, oor_sel, oor_q;
  logic          sel_b, wait_skip, done_a, done_b;
  logic [SW-1:0] starve_cnt;

`ifndef GSARB_SIZE_MASK_EN
  logic unused_gs_size;
  assign unused_gs_size = ^gs_size;
`endif

  always_comb begin
    a_edge   = (port_a.rd | port_a.wr) & ~a_req_q;
    b_edge   = (port_b.rd | port_b.wr) & ~b_req_q;
    starved  = (starve_cnt == SW'(STARVE_MAX));
    grant_b  = pend_b & (~pend_a | starved);
    sel_addr = grant_b ? b_addr_q : a_addr_q;
    sel_din  = grant_b ? b_din_q  : a_din_q;
    sel_we   = grant_b ? b_we_q   : a_we_q;
`ifdef GSARB_SIZE_MASK_EN
    case (gs_size)
      2'd0:    oor_sel = |sel_addr[AW-1:19];
      2'd1:    oor_sel = |sel_addr[AW-1:20];
      default: oor_sel = 1'b0;
    endcase
`else
    oor_sel = 1'b0;
`endif
    done_a   = (state == DONE) & ~sel_b;
    done_b   = (state == DONE) &  sel_b;
    state_nx = state;
    case (state)
      IDLE:    if (pend_a | pend_b) state_nx = oor_sel ? DONE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (!wait_skip && mem_ready) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Request level resets high so a request held through reset needs a fresh edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      a_req_q      <= 1'b1;
      b_req_q      <= 1'b1;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      a_din_q      <= '0;
      b_din_q      <= '0;
      a_we_q       <= 1'b0;
      b_we_q       <= 1'b0;
      sel_b        <= 1'b0;
      oor_q        <= 1'b0;
      wait_skip    <= 1'b0;
      starve_cnt   <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_rd       <= 1'b0;
      mem_we       <= 1'b0;
      port_a.dout  <= '0;
      port_b.dout  <= '0;
      port_a.ready <= 1'b1;
      port_b.ready <= 1'b1;
    end else begin
      a_req_q   <= port_a.rd | port_a.wr;
      b_req_q   <= port_b.rd | port_b.wr;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      wait_skip <= (state == ISSUE);

      if (state == IDLE && (pend_a || pend_b)) begin
        sel_b <= grant_b;
        oor_q <= oor_sel;
        if (!oor_sel) begin
          mem_addr <= sel_addr;
          mem_din  <= sel_din;
          mem_rd   <= ~sel_we;
          mem_we   <= sel_we;
        end
        if (grant_b || !pend_b) starve_cnt <= '0;
        else if (!starved)      starve_cnt <= starve_cnt + SW'(1);
      end else if (!pend_b) begin
        starve_cnt <= '0;
      end

      if (done_a) begin
        pend_a       <= 1'b0;
        port_a.ready <= 1'b1;
        if (!a_we_q) port_a.dout <= oor_q ? 8'hFF : mem_dout;
      end
      if (done_b) begin
        pend_b       <= 1'b0;
        port_b.ready <= 1'b1;
        if (!b_we_q) port_b.dout <= oor_q ? 8'hFF : mem_dout;
      end

      // Capture sits after completion so an edge landing on the port's own DONE edge is kept.
      if (a_edge && (!pend_a || done_a)) begin
        pend_a       <= 1'b1;
        a_addr_q     <= port_a.addr;
        a_din_q      <= port_a.din;
        a_we_q       <= port_a.wr;
        port_a.ready <= 1'b0;
      end
      if (b_edge && (!pend_b || done_b)) begin
        pend_b       <= 1'b1;
        b_addr_q     <= port_b.addr;
        b_din_q      <= port_b.din;
        b_we_q       <= port_b.wr;
        port_b.ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Scoreboard bench for gs_mem_arbiter: expected DDRAM ops and per-port read data are queued at stimulus time.
module tb_gs_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_rd, mem_we;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_ready = 1'b1;
  logic [1:0]  gs_size;
  int          mem_lat;

  gs_mem_arbiter_if #(.AW(21)) ia ();
  gs_mem_arbiter_if #(.AW(21)) ib ();

  gs_mem_arbiter #(.AW(21), .STARVE_MAX(4)) dut (
    .clk_sys  (clk),
    .reset_n  (rst_n),
    .port_a   (ia),
    .port_b   (ib),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_dout (mem_dout),
    .mem_ready(mem_ready),
    .gs_size  (gs_size)
  );

  always #5 clk = ~clk;

  // DDRAM model: busy for mem_lat cycles after it sees a strobe; not affected by the arbiter reset.
  logic [7:0]  mdl [0:4095];
  logic        mdl_init = 1'b0;
  logic [11:0] op_idx;
  logic        op_rd;
  int          lat_cnt;
  always @(posedge clk) begin
    if (!mdl_init) begin
      for (int i = 0; i < 4096; i++) mdl[i] <= 8'hEE;
      mdl[12'h345] <= 8'h5A;
      mdl[12'h100] <= 8'hA0;
      mdl[12'h101] <= 8'hA1;
      mdl[12'h102] <= 8'hA2;
      mdl[12'h103] <= 8'hA3;
      mdl[12'h104] <= 8'hA4;
      mdl[12'h040] <= 8'h77;
      mdl[12'h000] <= 8'h99;
      mdl_init     <= 1'b1;
    end
    if (mem_rd || mem_we) begin
      mem_ready <= 1'b0;
      lat_cnt   <= mem_lat;
      op_rd     <= mem_rd;
      op_idx    <= mem_addr[11:0];
      if (mem_we) mdl[mem_addr[11:0]] <= mem_din;
    end else if (!mem_ready) begin
      if (lat_cnt <= 1) begin
        mem_ready <= 1'b1;
        if (op_rd) mem_dout <= mdl[op_idx];
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  typedef struct packed {
    logic [20:0] addr;
    logic [7:0]  din;
    logic        we;
  } mem_op_t;

  mem_op_t    exp_mem[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int checks = 0;
  int errors = 0;

  task automatic push_mem(input logic [20:0] a, input logic [7:0] d, input logic we);
    mem_op_t t;
    t.addr = a;
    t.din  = d;
    t.we   = we;
    exp_mem.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input bit port_b_sel, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (port_b_sel ? ib.ready : ia.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: port %0d ready still 0 after 100 cycles, expected 1", port_b_sel);
    end
  endtask

  task automatic wait_strobe(input logic [20:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((mem_rd || mem_we) && mem_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: no strobe at %h within 100 cycles, expected one", a);
    end
  endtask

  task automatic gap(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe pops an expected DDRAM op, every ready rise pops an expected dout.
  initial begin : monitor
    logic    a_q, b_q;
    mem_op_t e;
    logic [7:0] d;
    a_q = 1'b1;
    b_q = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (mem_rd || mem_we) begin
          checks++;
          if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_op: unexpected rd=%0b we=%0b addr=%h, expected no strobe", mem_rd, mem_we, mem_addr);
          end else begin
            e = exp_mem.pop_front();
            if (mem_we !== e.we || mem_rd !== ~e.we || mem_addr !== e.addr || (e.we && mem_din !== e.din)) begin
              errors++;
              $display("FAIL mem_op: got rd=%0b we=%0b addr=%h din=%h, expected we=%0b addr=%h din=%h",
                       mem_rd, mem_we, mem_addr, mem_din, e.we, e.addr, e.din);
            end
          end
        end
        if (ia.ready && !a_q) begin
          checks++;
          if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL a_resp: unexpected completion dout=%h, expected none", ia.dout);
          end else begin
            d = exp_a.pop_front();
            if (ia.dout !== d) begin
              errors++;
              $display("FAIL a_resp: got dout=%h, expected %h", ia.dout, d);
            end
          end
        end
        if (ib.ready && !b_q) begin
          checks++;
          if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL b_resp: unexpected completion dout=%h, expected none", ib.dout);
          end else begin
            d = exp_b.pop_front();
            if (ib.dout !== d) begin
              errors++;
              $display("FAIL b_resp: got dout=%h, expected %h", ib.dout, d);
            end
          end
        end
      end
      a_q = ia.ready;
      b_q = ib.ready;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    ia.rd = 1'b1; ia.wr = 1'b0; ia.addr = '0; ia.din = '0;
    ib.rd = 1'b0; ib.wr = 1'b0; ib.addr = '0; ib.din = '0;
    gs_size = 2'd0;
    mem_lat = 1;
    rst_n   = 1'b0;
    gap(3);
    rst_n = 1'b1;

    // Reset values, with a_rd held high through and after reset: no strobe may appear.
    gap(8);
    chk("reset_a_ready", ia.ready, 1);
    chk("reset_b_ready", ib.ready, 1);
    chk("reset_a_dout", ia.dout, 0);
    chk("reset_b_dout", ib.dout, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_strobes", {mem_rd, mem_we}, 0);

    // Single A read; level held afterwards must not re-issue.
    ia.rd = 1'b0;
    gap(1);
    ia.addr = 21'h12345;
    push_mem(21'h12345, 8'h00, 1'b0);
    exp_a.push_back(8'h5A);
    ia.rd = 1'b1;
    wait_ready(1'b0, n);
    chk("a_read_latency", n, 6);
    gap(4);
    ia.rd = 1'b0;
    gap(1);

    // Simultaneous writes: A first, then B; writes leave dout unchanged.
    ia.addr = 21'h00010; ia.din = 8'h11; ia.wr = 1'b1;
    ib.addr = 21'h00020; ib.din = 8'h22; ib.wr = 1'b1;
    push_mem(21'h00010, 8'h11, 1'b1);
    push_mem(21'h00020, 8'h22, 1'b1);
    exp_a.push_back(8'h5A);
    exp_b.push_back(8'h00);
    wait_ready(1'b0, n);
    wait_ready(1'b1, n);
    ia.wr = 1'b0; ib.wr = 1'b0;
    gap(1);

    // B reads back its write, then rd+wr together must be a write.
    ib.addr = 21'h00020; ib.rd = 1'b1;
    push_mem(21'h00020, 8'h00, 1'b0);
    exp_b.push_back(8'h22);
    wait_ready(1'b1, n);
    ib.rd = 1'b0;
    gap(1);
    ib.addr = 21'h00030; ib.din = 8'h33; ib.rd = 1'b1; ib.wr = 1'b1;
    push_mem(21'h00030, 8'h33, 1'b1);
    exp_b.push_back(8'h22);
    wait_ready(1'b1, n);
    ib.rd = 1'b0; ib.wr = 1'b0;
    gap(1);
    ib.addr = 21'h00030; ib.rd = 1'b1;
    push_mem(21'h00030, 8'h00, 1'b0);
    exp_b.push_back(8'h33);
    wait_ready(1'b1, n);
    ib.rd = 1'b0;
    gap(1);

    // Starvation: A re-requests on each completion edge; B must win after the 4th A grant.
    for (int k = 0; k < 4; k++) push_mem(21'h00100 + 21'(k), 8'h00, 1'b0);
    push_mem(21'h00040, 8'h00, 1'b0);
    push_mem(21'h00104, 8'h00, 1'b0);
    exp_a.push_back(8'hA4);
    exp_b.push_back(8'h77);
    ia.addr = 21'h00100; ia.rd = 1'b1;
    ib.addr = 21'h00040; ib.rd = 1'b1;
    fork
      begin
        int na;
        for (int k = 0; k < 4; k++) begin
          wait_strobe(21'h00100 + 21'(k));
          ia.rd = 1'b0;
          gap(3);
          ia.addr = 21'h00101 + 21'(k);
          ia.rd   = 1'b1;
        end
        wait_ready(1'b0, na);
        ia.rd = 1'b0;
      end
      begin
        int nb;
        wait_ready(1'b1, nb);
        ib.rd = 1'b0;
      end
    join
    gap(2);

    // Starve counter back at zero: simultaneous requests go A then B again.
    ia.addr = 21'h12345; ia.rd = 1'b1;
    ib.addr = 21'h00020; ib.rd = 1'b1;
    push_mem(21'h12345, 8'h00, 1'b0);
    push_mem(21'h00020, 8'h00, 1'b0);
    exp_a.push_back(8'h5A);
    exp_b.push_back(8'h22);
    wait_ready(1'b0, n);
    wait_ready(1'b1, n);
    ia.rd = 1'b0; ib.rd = 1'b0;
    gap(1);

    // Reset during WAIT: outputs clear asynchronously, the late mem_ready rise is ignored.
    mem_lat = 3;
    ia.addr = 21'h00104; ia.rd = 1'b1;
    push_mem(21'h00104, 8'h00, 1'b0);
    wait_strobe(21'h00104);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_strobes", {mem_rd, mem_we}, 0);
    chk("async_rst_a_ready", ia.ready, 1);
    chk("async_rst_b_ready", ib.ready, 1);
    chk("async_rst_a_dout", ia.dout, 0);
    ia.rd = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(8);
    chk("post_rst_a_dout", ia.dout, 0);
    chk("post_rst_a_ready", ia.ready, 1);
    mem_lat = 1;

    // Address beyond the 512KB window.
    gs_size = 2'd0;
    ia.addr = 21'h80000; ia.rd = 1'b1;
`ifdef GSARB_SIZE_MASK_EN
    exp_a.push_back(8'hFF);
    wait_ready(1'b0, n);
    chk("masked_read_latency", n, 3);
`else
    push_mem(21'h80000, 8'h00, 1'b0);
    exp_a.push_back(8'h99);
    wait_ready(1'b0, n);
    chk("unmasked_read_latency", n, 6);
`endif
    ia.rd = 1'b0;
    gap(10);

    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gs_mem_arbiter.md
Name: gs_mem_arbiter

Overview:
- Shares the single byte-wide DDRAM request port, which backs General Sound memory, between two requesters.
- Port A: GS Z80 memory bus (latency-critical, high priority).
- Port B: HPS ioctl loader, which preloads GS ROM/RAM images.
- Sits between the tsconf GS_* bus and the ddram block; serializes accesses, returns read data, drives per-port ready/wait.

Parameters:
- AW, 21, byte address width (2MB GS space).
- STARVE_MAX, 4, consecutive A grants allowed while B pending before B is forced.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_addr  in  AW  port A address
- a_din  in  8  port A write data
- a_rd  in  1  port A read request (level, held until ready)
- a_wr  in  1  port A write request (level, held until ready)
- a_dout  out  8  port A read data
- a_ready  out  1  port A idle/done (GS_WAIT = ~a_ready)
- b_addr, b_din, b_rd, b_wr, b_dout, b_ready: same as port A, for port B
- mem_addr  out  AW  DDRAM address
- mem_din  out  8  DDRAM write data
- mem_rd  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_dout  in  8  DDRAM read data, valid when mem_ready rises
- mem_ready  in  1  low while DDRAM busy
- gs_size  in  2  0=512KB, 1=1MB, 2/3=2MB (used only with optional feature)

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is asynchronous, active-low.
- Reset values: all outputs 0, except a_ready=1 and b_ready=1. State IDLE, pending flags 0, starve counter 0.
- Request capture:
  - Per port, a request is the rising edge of (rd|wr), registered.
  - Capture sets pend_x, latches addr/din/type, and drops x_ready the next cycle.
  - Level held after completion does not re-issue. The port must deassert rd/wr for ≥1 cycle before its next request.
- States:
  - IDLE: if any pend, select a port and go to ISSUE.
  - ISSUE: drive mem_addr/mem_din, pulse mem_rd or mem_we for exactly 1 cycle, go to WAIT.
  - WAIT: wait for mem_ready low→high. Ignore mem_ready for the first cycle after the strobe (ddram deasserts one cycle late). On high, go to DONE.
  - DONE: for reads, x_dout <= mem_dout. Clear pend_x, set x_ready=1, go to IDLE.
- Arbitration:
  - A wins if pend_a, unless starve_cnt==STARVE_MAX and pend_b, in which case B wins.
  - starve_cnt increments on each A grant while pend_b=1, saturating at STARVE_MAX. It resets to 0 on any B grant or when pend_b=0.
  - Decision is made only in IDLE; a granted access is never preempted.
- Latency (ideal DDRAM, mem_ready high 2 cycles after strobe): edge to x_ready high = 6 cycles; back-to-back grant gap = 1 IDLE cycle.
- x_dout holds its last read value until the next completed read on that port; writes leave it unchanged.
- Simultaneous new A and B edges in the same cycle: both captured; A served first (if starve counter permits).
- New request from the currently served port during WAIT: impossible by protocol (rd/wr held). If observed, ignored until DONE.
- If rd and wr are both high at the edge, wr is taken.
- Asynchronous reset mid-access:
  - Aborts immediately; pending requests are lost; mem strobes are 0.
  - An outstanding DDRAM transaction completes silently, and its mem_ready rise is ignored (state is IDLE).

Optional Feature:
- Macro GSARB_SIZE_MASK_EN.
- Defined: a request with address beyond the gs_size limit is not issued to DDRAM.
  - Limits: 512KB means addr[20:19]≠0 is out; 1MB means addr[20]=1 is out.
  - The state goes IDLE→DONE directly. Reads return 8'hFF; writes are dropped. Latency is 3 cycles.
  - These requests take part in starve counting normally.
- Undefined: gs_size is ignored, all addresses are issued, and the upper-level mask handles 8'hFF.

Test Plan:
- Reset with a_rd held high, then release reset_n → a_ready=1, no mem strobe until a_rd falls and rises again.
- a_rd at 0x12345, mem_dout=0x5A → single mem_rd pulse with mem_addr=0x12345; a_ready low then high; a_dout=0x5A.
- a_wr and b_wr raised in the same cycle (0x00010/0x11, 0x00020/0x22) → A write issued first, then B; exactly two mem_we pulses in that order.
- B held pending while A issues continuous reads, STARVE_MAX=4 → B granted after the 4th A grant; starve_cnt returns to 0.
- reset_n pulled low during WAIT → all mem outputs 0 and both ready=1 asynchronously; the late mem_ready rise causes no dout update.
- With GSARB_SIZE_MASK_EN, gs_size=0, a_rd at 0x80000 → no mem_rd; a_dout=8'hFF; a_ready high 3 cycles after the edge.
